// File: rtl/selection_credit.sv
// Per-input output-direction selection with per-direction downstream credit tracking.
// Each input locks the candidate with the most credits until its packet tail departs.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | no direction held; evaluates the candidate list every cycle
// S_LOCKED | direction held for the current packet until i_release
module selection_credit #(
   parameter int N            = 5,
   parameter int M            = 3,
   parameter int CREDIT_DEPTH = 4,
   parameter int CW           = $clog2(CREDIT_DEPTH + 1)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [0:N-1]               i_select_neighbor,
   input  logic [0:N-1][0:M-1][1:0]   i_avail_directions,
   input  logic [0:N-1]               i_release,
   input  logic [0:3]                 i_flit_sent,
   input  logic [0:3]                 i_credit_return,
   output logic [0:N-1]               o_output_valid,
   output logic [0:N-1][1:0]          o_output_dir,
   output logic [0:3][CW-1:0]         o_credits,
   output logic                       o_credit_err
);

   typedef enum logic {S_IDLE = 1'b0, S_LOCKED = 1'b1} state_t;

   state_t                state_q [N];
   state_t                state_d [N];
   logic [0:N-1][1:0]     dir_q, dir_d;
   logic [0:3][CW-1:0]    credits_q, credits_d;
   logic                  err_q, err_d;

   always_comb begin
      credits_d = credits_q;
      err_d     = err_q;
      for (int d = 0; d < 4; d++) begin
         if (i_flit_sent[d] && !i_credit_return[d]) begin
            if (credits_q[d] == '0) err_d = 1'b1;
            else                    credits_d[d] = credits_q[d] - CW'(1);
         end else if (i_credit_return[d] && !i_flit_sent[d]) begin
            if (credits_q[d] == CW'(CREDIT_DEPTH)) err_d = 1'b1;
            else                                  credits_d[d] = credits_q[d] + CW'(1);
         end
      end
   end

   // Selection reads credits_q, i.e. the value before this cycle's update.
   always_comb begin
      int          cnt;
      logic        found;
      logic [1:0]  best_dir;
      logic [CW-1:0] best_cred;
      logic [1:0]  cand;
      dir_d = dir_q;
      for (int i = 0; i < N; i++) begin
         state_d[i] = state_q[i];
         cnt        = int'(i_avail_directions[i][M-1]);
         found      = 1'b0;
         best_dir   = 2'd0;
         best_cred  = '0;
         for (int s = 0; s < M - 1; s++) begin
            cand = i_avail_directions[i][s];
            // Strict compare keeps the lowest slot on a tie.
            if (s < cnt && credits_q[cand] > best_cred) begin
               found     = 1'b1;
               best_dir  = cand;
               best_cred = credits_q[cand];
            end
         end
         case (state_q[i])
            S_IDLE: begin
               if (i_select_neighbor[i] && cnt > 0 && cnt <= M - 1 && found) begin
                  state_d[i] = S_LOCKED;
                  dir_d[i]   = best_dir;
               end
            end
            S_LOCKED: begin
               if (i_release[i]) state_d[i] = S_IDLE;
            end
            default: state_d[i] = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N; i++) state_q[i] <= S_IDLE;
         dir_q <= '0;
         for (int d = 0; d < 4; d++) credits_q[d] <= CW'(CREDIT_DEPTH);
         err_q <= 1'b0;
      end else begin
         for (int i = 0; i < N; i++) state_q[i] <= state_d[i];
         dir_q     <= dir_d;
         credits_q <= credits_d;
         err_q     <= err_d;
      end
   end

   always_comb begin
      for (int i = 0; i < N; i++) o_output_valid[i] = (state_q[i] == S_LOCKED);
   end

   assign o_output_dir = dir_q;
   assign o_credits    = credits_q;
   assign o_credit_err = err_q;

endmodule

// File: tb/tb_selection_credit.sv
// Bench for selection_credit: directed vector table plus randomized traffic,
// both checked every cycle against an arithmetic reference model.
module tb_selection_credit;

   localparam int N  = 5;
   localparam int M  = 3;
   localparam int CD = 4;
   localparam int CW = $clog2(CD + 1);

   logic                      clk;
   logic                      reset;
   logic [0:N-1]              sel;
   logic [0:N-1][0:M-1][1:0]  avail;
   logic [0:N-1]              rel;
   logic [0:3]                sent;
   logic [0:3]                ret;
   logic [0:N-1]              o_output_valid;
   logic [0:N-1][1:0]         o_output_dir;
   logic [0:3][CW-1:0]        o_credits;
   logic                      o_credit_err;

   int checks = 0;
   int errors = 0;

   int m_cred [4];
   int m_err;
   int m_v [N];
   int m_d [N];

   selection_credit #(.N(N), .M(M), .CREDIT_DEPTH(CD)) dut (
      .clk                (clk),
      .reset              (reset),
      .i_select_neighbor  (sel),
      .i_avail_directions (avail),
      .i_release          (rel),
      .i_flit_sent        (sent),
      .i_credit_return    (ret),
      .o_output_valid     (o_output_valid),
      .o_output_dir       (o_output_dir),
      .o_credits          (o_credits),
      .o_credit_err       (o_credit_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      int         req_in;
      int         cnt;
      int         s0;
      int         s1;
      int         rel_i;
      int         sent_d;
      int         ret_d;
      int         chk_in;
      int         exp_v;
      int         exp_d;
      int         exp_c [4];
      int         exp_e;
   } vec_t;

   vec_t vq [$];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: apply the rules to the current inputs, as of the coming edge.
   task automatic model_step();
      int cnt, best, bc, c, slot;
      if (reset) begin
         for (int d = 0; d < 4; d++) m_cred[d] = CD;
         m_err = 0;
         for (int i = 0; i < N; i++) begin m_v[i] = 0; m_d[i] = 0; end
         return;
      end
      for (int i = 0; i < N; i++) begin
         if (m_v[i] == 1) begin
            if (rel[i]) m_v[i] = 0;
         end else if (sel[i]) begin
            cnt = int'(avail[i][M-1]);
            if (cnt >= 1 && cnt <= M - 1) begin
               best = -1; bc = 0;
               for (int s = 0; s < cnt; s++) begin
                  slot = int'(avail[i][s]);
                  c = m_cred[slot];
                  if (c > bc) begin bc = c; best = slot; end
               end
               if (best >= 0) begin m_v[i] = 1; m_d[i] = best; end
            end
         end
      end
      for (int d = 0; d < 4; d++) begin
         if (sent[d] && !ret[d]) begin
            if (m_cred[d] == 0) m_err = 1; else m_cred[d]--;
         end else if (ret[d] && !sent[d]) begin
            if (m_cred[d] == CD) m_err = 1; else m_cred[d]++;
         end
      end
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         chk($sformatf("model_valid[%0d]", i), int'(o_output_valid[i]), m_v[i]);
         chk($sformatf("model_dir[%0d]", i), int'(o_output_dir[i]), m_d[i]);
      end
      for (int d = 0; d < 4; d++)
         chk($sformatf("model_credits[%0d]", d), int'(o_credits[d]), m_cred[d]);
      chk("model_err", int'(o_credit_err), m_err);
   endtask

   function automatic vec_t mk(input logic rst, input int req_in, input int cnt,
                               input int s0, input int s1, input int rel_i,
                               input int sent_d, input int ret_d, input int chk_in,
                               input int ev, input int ed, input int c0, input int c1,
                               input int c2, input int c3, input int ee);
      vec_t v;
      v.rst = rst; v.req_in = req_in; v.cnt = cnt; v.s0 = s0; v.s1 = s1;
      v.rel_i = rel_i; v.sent_d = sent_d; v.ret_d = ret_d; v.chk_in = chk_in;
      v.exp_v = ev; v.exp_d = ed;
      v.exp_c[0] = c0; v.exp_c[1] = c1; v.exp_c[2] = c2; v.exp_c[3] = c3;
      v.exp_e = ee;
      return v;
   endfunction

   task automatic clear_inputs();
      reset = 1'b0; sel = '0; avail = '0; rel = '0; sent = '0; ret = '0;
   endtask

   initial begin
      vec_t v;
      clear_inputs();
      reset = 1'b1;
      for (int i = 0; i < N; i++) begin m_v[i] = 0; m_d[i] = 0; end
      for (int d = 0; d < 4; d++) m_cred[d] = CD;
      m_err = 0;

      //          rst req cnt s0 s1 rel snt ret chk v  d  c0 c1 c2 c3 e
      vq.push_back(mk(1, -1, 0, 0, 0, -1, -1, -1, 1, 0, 0, 4, 4, 4, 4, 0));
      vq.push_back(mk(0,  1, 1, 1, 0, -1, -1, -1, 1, 1, 1, 4, 4, 4, 4, 0));
      vq.push_back(mk(0, -1, 0, 0, 0,  1, -1, -1, 1, 0, 1, 4, 4, 4, 4, 0));
      vq.push_back(mk(0, -1, 0, 0, 0, -1,  0, -1, 2, 0, 0, 3, 4, 4, 4, 0));
      vq.push_back(mk(0, -1, 0, 0, 0, -1,  0, -1, 2, 0, 0, 2, 4, 4, 4, 0));
      vq.push_back(mk(0, -1, 0, 0, 0, -1,  0, -1, 2, 0, 0, 1, 4, 4, 4, 0));
      vq.push_back(mk(0, -1, 0, 0, 0, -1,  1, -1, 2, 0, 0, 1, 3, 4, 4, 0));
      vq.push_back(mk(0,  2, 2, 0, 1, -1, -1, -1, 2, 1, 1, 1, 3, 4, 4, 0));
      vq.push_back(mk(0, -1, 0, 0, 0,  2, -1, -1, 2, 0, 1, 1, 3, 4, 4, 0));
      vq.push_back(mk(0, -1, 0, 0, 0, -1, -1,  0, 2, 0, 1, 2, 3, 4, 4, 0));
      vq.push_back(mk(0, -1, 0, 0, 0, -1, -1,  0, 2, 0, 1, 3, 3, 4, 4, 0));
      vq.push_back(mk(0, -1, 0, 0, 0, -1, -1,  0, 2, 0, 1, 4, 3, 4, 4, 0));
      vq.push_back(mk(0, -1, 0, 0, 0, -1, -1,  1, 2, 0, 1, 4, 4, 4, 4, 0));
      vq.push_back(mk(0,  2, 2, 0, 1, -1, -1, -1, 2, 1, 0, 4, 4, 4, 4, 0));
      vq.push_back(mk(0, -1, 0, 0, 0,  2, -1, -1, 2, 0, 0, 4, 4, 4, 4, 0));
      vq.push_back(mk(0, -1, 0, 0, 0, -1,  3, -1, 0, 0, 0, 4, 4, 4, 3, 0));
      vq.push_back(mk(0, -1, 0, 0, 0, -1,  3, -1, 0, 0, 0, 4, 4, 4, 2, 0));
      vq.push_back(mk(0, -1, 0, 0, 0, -1,  3, -1, 0, 0, 0, 4, 4, 4, 1, 0));
      vq.push_back(mk(0, -1, 0, 0, 0, -1,  3, -1, 0, 0, 0, 4, 4, 4, 0, 0));
      vq.push_back(mk(0,  0, 1, 3, 0, -1, -1, -1, 0, 0, 0, 4, 4, 4, 0, 0));
      vq.push_back(mk(0,  0, 1, 3, 0, -1, -1,  3, 0, 0, 0, 4, 4, 4, 1, 0));
      vq.push_back(mk(0,  0, 1, 3, 0, -1, -1, -1, 0, 1, 3, 4, 4, 4, 1, 0));
      vq.push_back(mk(0, -1, 0, 0, 0,  0, -1, -1, 0, 0, 3, 4, 4, 4, 1, 0));
      vq.push_back(mk(0,  3, 1, 2, 0, -1, -1, -1, 3, 1, 2, 4, 4, 4, 1, 0));
      vq.push_back(mk(0,  3, 1, 0, 0, -1, -1, -1, 3, 1, 2, 4, 4, 4, 1, 0));
      vq.push_back(mk(0,  3, 1, 0, 0,  3, -1, -1, 3, 0, 2, 4, 4, 4, 1, 0));
      vq.push_back(mk(0,  3, 1, 0, 0, -1, -1, -1, 3, 1, 0, 4, 4, 4, 1, 0));
      vq.push_back(mk(0, -1, 0, 0, 0,  3, -1, -1, 3, 0, 0, 4, 4, 4, 1, 0));
      vq.push_back(mk(0, -1, 0, 0, 0, -1,  1, -1, 3, 0, 0, 4, 3, 4, 1, 0));
      vq.push_back(mk(0, -1, 0, 0, 0, -1,  1, -1, 3, 0, 0, 4, 2, 4, 1, 0));
      vq.push_back(mk(0, -1, 0, 0, 0, -1,  1,  1, 3, 0, 0, 4, 2, 4, 1, 0));
      vq.push_back(mk(0, -1, 0, 0, 0, -1, -1,  2, 3, 0, 0, 4, 2, 4, 1, 1));
      vq.push_back(mk(0, -1, 0, 0, 0, -1,  0, -1, 3, 0, 0, 3, 2, 4, 1, 1));
      vq.push_back(mk(0, -1, 0, 0, 0, -1,  0, -1, 3, 0, 0, 2, 2, 4, 1, 1));
      vq.push_back(mk(0, -1, 0, 0, 0, -1,  0, -1, 3, 0, 0, 1, 2, 4, 1, 1));
      vq.push_back(mk(0, -1, 0, 0, 0, -1,  0, -1, 3, 0, 0, 0, 2, 4, 1, 1));
      vq.push_back(mk(0, -1, 0, 0, 0, -1,  0, -1, 3, 0, 0, 0, 2, 4, 1, 1));
      vq.push_back(mk(0,  0, 1, 1, 0, -1, -1, -1, 0, 1, 1, 0, 2, 4, 1, 1));
      vq.push_back(mk(0,  4, 2, 0, 1, -1, -1, -1, 4, 1, 1, 0, 2, 4, 1, 1));
      vq.push_back(mk(0, -1, 0, 0, 0, -1,  2, -1, 4, 1, 1, 0, 2, 3, 1, 1));
      vq.push_back(mk(1, -1, 0, 0, 0, -1, -1, -1, 0, 0, 0, 4, 4, 4, 4, 0));
      vq.push_back(mk(0,  4, 1, 3, 0, -1, -1, -1, 4, 1, 3, 4, 4, 4, 4, 0));
      vq.push_back(mk(0, -1, 0, 0, 0,  4, -1, -1, 4, 0, 3, 4, 4, 4, 4, 0));
      vq.push_back(mk(0,  1, 3, 1, 2, -1, -1, -1, 1, 0, 0, 4, 4, 4, 4, 0));
      vq.push_back(mk(0,  1, 0, 1, 2, -1, -1, -1, 1, 0, 0, 4, 4, 4, 4, 0));

      for (int k = 0; k < vq.size(); k++) begin
         v = vq[k];
         clear_inputs();
         reset = v.rst;
         if (v.req_in >= 0) begin
            sel[v.req_in]         = 1'b1;
            avail[v.req_in][0]    = 2'(v.s0);
            avail[v.req_in][1]    = 2'(v.s1);
            avail[v.req_in][M-1]  = 2'(v.cnt);
         end
         if (v.rel_i  >= 0) rel[v.rel_i]   = 1'b1;
         if (v.sent_d >= 0) sent[v.sent_d] = 1'b1;
         if (v.ret_d  >= 0) ret[v.ret_d]   = 1'b1;
         cycle();
         chk($sformatf("vec%0d_valid[%0d]", k, v.chk_in), int'(o_output_valid[v.chk_in]), v.exp_v);
         chk($sformatf("vec%0d_dir[%0d]", k, v.chk_in), int'(o_output_dir[v.chk_in]), v.exp_d);
         for (int d = 0; d < 4; d++)
            chk($sformatf("vec%0d_credits[%0d]", k, d), int'(o_credits[d]), v.exp_c[d]);
         chk($sformatf("vec%0d_err", k), int'(o_credit_err), v.exp_e);
      end

      for (int k = 0; k < 400; k++) begin
         clear_inputs();
         reset = ($urandom_range(0, 99) == 0);
         for (int i = 0; i < N; i++) begin
            sel[i] = ($urandom_range(0, 2) == 0);
            rel[i] = ($urandom_range(0, 3) == 0);
            for (int s = 0; s < M - 1; s++) avail[i][s] = 2'($urandom_range(0, 3));
            avail[i][M-1] = 2'($urandom_range(0, 3));
         end
         for (int d = 0; d < 4; d++) begin
            sent[d] = ($urandom_range(0, 2) == 0);
            ret[d]  = ($urandom_range(0, 2) == 0);
         end
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
